// File: rtl/monitor_pkg.sv
// Shared state encoding, error codes and default parameters for the monitor
// UART command engine.
package monitor_pkg;

   localparam int CLK_FRQ            = 50_000_000;
   localparam int DEF_CMD_BYTES      = 1;
   localparam int DEF_SIZE_BYTES     = 1;
   localparam int DEF_MAX_PAYLOAD    = 16;
   localparam int DEF_TIMEOUT_CYCLES = CLK_FRQ / 100;  // 10 ms between bytes

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_RECV_CMD   = 3'd1,
      S_RECV_SIZE  = 3'd2,
      S_WRITE      = 3'd3,
      S_READ_FETCH = 3'd4,
      S_READ_SEND  = 3'd5,
      S_ERROR      = 3'd6
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_RX      = 2'd1;
   localparam logic [1:0] ERR_SIZE    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/monitor_timeout.sv
// Inter-byte watchdog: counts cycles since the last restart and flags expiry
// once TIMEOUT_CYCLES cycles have elapsed since the restarting cycle.
module monitor_timeout
   import monitor_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // The restart cycle itself counts as cycle 0, so the first cycle after it
   // already holds 1 and expiry lands exactly TIMEOUT_CYCLES cycles later.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset)
         count <= '0;
      else if (restart)
         count <= CNT_W'(1);
      else if (count != LAST)
         count <= count + CNT_W'(1);
   end

   assign expired = !restart && (count == LAST);

endmodule

// File: rtl/monitor_cmd_engine.sv
// Command-protocol engine for the monitor UART link: receives a command and
// size header, then buffers a write payload or streams a read response.
module monitor_cmd_engine
   import monitor_pkg::*;
#(
   parameter int CMD_BYTES      = DEF_CMD_BYTES,
   parameter int SIZE_BYTES     = DEF_SIZE_BYTES,
   parameter int MAX_PAYLOAD    = DEF_MAX_PAYLOAD,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               rx_valid,
   input  logic [7:0]                         rx_byte,
   input  logic                               rx_error,
   output logic                               tx_write,
   output logic [7:0]                         tx_byte,
   input  logic                               tx_done,
   input  logic                               uart_rts,
   output logic                               uart_cts,
   output logic [2:0]                         state,
   output logic [8*CMD_BYTES-1:0]             cmd,
   output logic                               cmd_rw,
   output logic [8*CMD_BYTES-2:0]             cmd_id,
   output logic [8*SIZE_BYTES-1:0]            data_size,
   output logic [8*MAX_PAYLOAD-1:0]           cmd_data,
   output logic [$clog2(MAX_PAYLOAD+1)-1:0]   cmd_data_idx,
   output logic                               wr_done,
   output logic                               rd_req,
   output logic [$clog2(MAX_PAYLOAD+1)-1:0]   rd_idx,
   input  logic                               rd_ack,
   input  logic [7:0]                         rd_byte,
   output logic                               err,
   output logic [1:0]                         err_code
);

   localparam int CMD_W  = 8 * CMD_BYTES;
   localparam int SIZE_W = 8 * SIZE_BYTES;
   localparam int IDX_W  = $clog2(MAX_PAYLOAD + 1);
   localparam int HDR_W  = $clog2(max_int(CMD_BYTES, SIZE_BYTES) + 1);
   localparam int CMP_W  = max_int(SIZE_W, IDX_W);

   state_t            state_r;
   logic [HDR_W-1:0]  byte_cnt;
   logic [CMD_W-1:0]  cmd_sr, cmd_shift;
   logic [SIZE_W-1:0] size_sr, size_shift;
   logic [IDX_W-1:0]  idx_inc;
   logic              idx_done, size_over;
   logic              rx_abort, tmo_restart, tmo_expired;

   assign state      = state_r;
   assign cmd_rw     = cmd[CMD_W-1];
   assign cmd_id     = cmd[CMD_W-2:0];
   assign cmd_shift  = CMD_W'({cmd_sr, rx_byte});
   assign size_shift = SIZE_W'({size_sr, rx_byte});
   assign idx_inc    = cmd_data_idx + IDX_W'(1);
   assign idx_done   = (CMP_W'(idx_inc) == CMP_W'(data_size));
   assign size_over  = (CMP_W'(size_shift) > CMP_W'(MAX_PAYLOAD));
   assign rx_abort   = rx_error && (state_r inside {S_RECV_CMD, S_RECV_SIZE, S_WRITE});

   // Every move into a watched state coincides with an rx/tx/rd event or
   // leaves IDLE, so these terms also cover the restart-on-state-change rule.
   assign tmo_restart = rx_valid || tx_done || rd_ack ||
                        (state_r == S_IDLE) || (state_r == S_ERROR);

   monitor_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .restart(tmo_restart),
      .expired(tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= S_IDLE;
         uart_cts     <= 1'b1;
         byte_cnt     <= '0;
         cmd_sr       <= '0;
         size_sr      <= '0;
         cmd          <= '0;
         data_size    <= '0;
         // NOTE: the payload buffer is a flop vector, not a RAM, so it is
         // reset together with the rest of the visible state.
         cmd_data     <= '0;
         cmd_data_idx <= '0;
         rd_idx       <= '0;
         tx_byte      <= '0;
         tx_write     <= 1'b0;
         wr_done      <= 1'b0;
         rd_req       <= 1'b0;
         err          <= 1'b0;
         err_code     <= ERR_NONE;
      end else begin
         tx_write <= 1'b0;
         wr_done  <= 1'b0;
         rd_req   <= 1'b0;
         err      <= 1'b0;

         if (rx_abort || tmo_expired) begin
            state_r  <= S_ERROR;
            uart_cts <= 1'b1;
            err      <= 1'b1;
            err_code <= rx_abort ? ERR_RX : ERR_TIMEOUT;
         end else begin
            unique case (state_r)
               S_IDLE: begin
                  if (!uart_rts) begin
                     state_r  <= S_RECV_CMD;
                     uart_cts <= 1'b0;
                     byte_cnt <= '0;
                  end
               end

               S_RECV_CMD: begin
                  if (rx_valid) begin
                     cmd_sr   <= cmd_shift;
                     byte_cnt <= byte_cnt + HDR_W'(1);
                     if (byte_cnt == HDR_W'(CMD_BYTES - 1)) begin
                        cmd      <= cmd_shift;
                        byte_cnt <= '0;
                        state_r  <= S_RECV_SIZE;
                     end
                  end
               end

               S_RECV_SIZE: begin
                  if (rx_valid) begin
                     size_sr  <= size_shift;
                     byte_cnt <= byte_cnt + HDR_W'(1);
                     if (byte_cnt == HDR_W'(SIZE_BYTES - 1)) begin
                        data_size <= size_shift;
                        if (size_over) begin
                           state_r  <= S_ERROR;
                           uart_cts <= 1'b1;
                           err      <= 1'b1;
                           err_code <= ERR_SIZE;
                        end else if (size_shift == '0) begin
                           wr_done  <= cmd_rw;
                           state_r  <= S_IDLE;
                           uart_cts <= 1'b1;
                        end else begin
                           cmd_data_idx <= '0;
                           cmd_data     <= '0;
                           if (cmd_rw) begin
                              state_r <= S_WRITE;
                           end else begin
                              state_r  <= S_READ_FETCH;
                              uart_cts <= 1'b1;
                              rd_req   <= 1'b1;
                              rd_idx   <= '0;
                           end
                        end
                     end
                  end
               end

               S_WRITE: begin
                  if (rx_valid) begin
                     for (int i = 0; i < MAX_PAYLOAD; i++)
                        if (cmd_data_idx == IDX_W'(i))
                           cmd_data[8*i +: 8] <= rx_byte;
                     cmd_data_idx <= idx_inc;
                     if (idx_done) begin
                        wr_done  <= 1'b1;
                        state_r  <= S_IDLE;
                        uart_cts <= 1'b1;
                     end
                  end
               end

               S_READ_FETCH: begin
                  if (rd_ack) begin
                     tx_byte  <= rd_byte;
                     tx_write <= 1'b1;
                     state_r  <= S_READ_SEND;
                  end
               end

               S_READ_SEND: begin
                  if (tx_done) begin
                     cmd_data_idx <= idx_inc;
                     if (idx_done) begin
                        state_r <= S_IDLE;
                     end else begin
                        state_r <= S_READ_FETCH;
                        rd_req  <= 1'b1;
                        rd_idx  <= idx_inc;
                     end
                  end
               end

               S_ERROR: begin
                  state_r <= S_IDLE;
               end

               default: begin
                  state_r  <= S_IDLE;
                  uart_cts <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_monitor_cmd_engine.sv
// Scoreboard bench for monitor_cmd_engine: directed transactions push expected
// events; a monitor pops and compares whenever the engine emits one.
module tb_monitor_cmd_engine;

   localparam int MAX_PAYLOAD    = 16;
   localparam int TIMEOUT_CYCLES = 100;
   localparam int IDX_W          = $clog2(MAX_PAYLOAD + 1);

   typedef enum logic [1:0] {EV_WR, EV_RDREQ, EV_TX, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t      kind;
      logic [15:0]   a;
      logic [127:0]  b;
      int            cyc;
   } ev_t;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     rx_valid, rx_error, tx_done, uart_rts, rd_ack;
   logic [7:0]               rx_byte, rd_byte;
   logic                     tx_write, uart_cts, cmd_rw, wr_done, rd_req, err;
   logic [7:0]               tx_byte, cmd, data_size;
   logic [6:0]               cmd_id;
   logic [2:0]               state;
   logic [8*MAX_PAYLOAD-1:0] cmd_data;
   logic [IDX_W-1:0]         cmd_data_idx, rd_idx;
   logic [1:0]               err_code;

   ev_t        exp_q[$];
   ev_t        act;
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         t_last = 0;
   logic [7:0] rd_mem [0:1];
   logic [IDX_W-1:0] ri;

   monitor_cmd_engine #(
      .CMD_BYTES(1), .SIZE_BYTES(1),
      .MAX_PAYLOAD(MAX_PAYLOAD), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset(reset),
      .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
      .tx_write(tx_write), .tx_byte(tx_byte), .tx_done(tx_done),
      .uart_rts(uart_rts), .uart_cts(uart_cts), .state(state),
      .cmd(cmd), .cmd_rw(cmd_rw), .cmd_id(cmd_id), .data_size(data_size),
      .cmd_data(cmd_data), .cmd_data_idx(cmd_data_idx), .wr_done(wr_done),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_byte(rd_byte),
      .err(err), .err_code(err_code)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d events pending", exp_q.size());
      $fatal(1, "watchdog expired");
   end

   function automatic void expect_ev(input ev_kind_t k, input logic [15:0] ea,
                                     input logic [127:0] eb, input int ec);
      ev_t e;
      e.kind = k; e.a = ea; e.b = eb; e.cyc = ec;
      exp_q.push_back(e);
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic score(input ev_t got);
      ev_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_%s: got a=%0h b=%0h at cycle %0d, nothing expected",
                  got.kind.name(), got.a, got.b, got.cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != got.kind || e.a !== got.a || e.b !== got.b ||
             (e.cyc >= 0 && e.cyc != got.cyc)) begin
            miscompares++;
            $display("FAIL event_%s: got %s a=%0h b=%0h cyc=%0d, want a=%0h b=%0h cyc=%0d",
                     e.kind.name(), got.kind.name(), got.a, got.b, got.cyc, e.a, e.b, e.cyc);
         end
      end
   endtask

   // Monitor: every output event is scored against the head of the queue.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         act.cyc = cyc;
         if (err) begin
            act.kind = EV_ERR; act.a = 16'(err_code); act.b = 128'(uart_cts); score(act);
         end
         if (wr_done) begin
            act.kind = EV_WR; act.a = {cmd, data_size}; act.b = cmd_data; score(act);
         end
         if (rd_req) begin
            act.kind = EV_RDREQ; act.a = 16'(rd_idx); act.b = '0; score(act);
         end
         if (tx_write) begin
            act.kind = EV_TX; act.a = 16'(tx_byte); act.b = '0; score(act);
         end
      end
   end

   // Register-space responder: rd_ack three cycles after each rd_req.
   initial forever begin
      @(negedge clk);
      if (rd_req) begin
         ri = rd_idx;
         repeat (3) @(posedge clk);
         #1 rd_ack = 1'b1; rd_byte = rd_mem[ri[0]];
         @(posedge clk);
         #1 rd_ack = 1'b0;
      end
   end

   // UART transmitter model: tx_done four cycles after each tx_write.
   initial forever begin
      @(negedge clk);
      if (tx_write) begin
         repeat (4) @(posedge clk);
         #1 tx_done = 1'b1;
         @(posedge clk);
         #1 tx_done = 1'b0;
      end
   end

   task automatic start_txn();
      int n;
      // NOTE: inputs change with blocking assignments 1 time unit after the
      // edge, so the DUT never races the stimulus.
      @(posedge clk); #1 uart_rts = 1'b0;
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         if (uart_cts == 1'b0) break;
         n++;
      end
      check("cts_low_on_start", uart_cts, 1'b0);
      @(posedge clk); #1 uart_rts = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic e);
      @(posedge clk);
      #1 rx_valid = 1'b1; rx_byte = b; rx_error = e; t_last = cyc;
      @(posedge clk);
      #1 rx_valid = 1'b0; rx_error = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (state !== 3'd0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({name, "_back_to_idle"}, state, 3'd0);
      repeat (6) @(negedge clk);
      check({name, "_no_pending_events"}, exp_q.size(), 0);
   endtask

   initial begin
      reset = 1'b1; uart_rts = 1'b1; rx_valid = 1'b0; rx_error = 1'b0;
      rx_byte = '0; tx_done = 1'b0; rd_ack = 1'b0; rd_byte = '0;
      rd_mem[0] = 8'h5A; rd_mem[1] = 8'hA5;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_state", state, 3'd0);
      check("reset_cts", uart_cts, 1'b1);
      check("reset_outputs", {cmd, data_size, cmd_data_idx, rd_idx, tx_byte, err_code},
            '0);
      check("reset_pulses", {wr_done, rd_req, tx_write, err}, 4'b0);

      // Write of three bytes
      expect_ev(EV_WR, 16'h8503, 128'hCCBBAA, -1);
      start_txn();
      send_byte(8'h85, 0); send_byte(8'h03, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
      wait_idle("write");
      check("write_cmd_id", cmd_id, 7'h05);
      check("write_cmd_rw", cmd_rw, 1'b1);
      check("write_cts_high", uart_cts, 1'b1);

      // Read of two bytes
      expect_ev(EV_RDREQ, 16'd0, '0, -1);
      expect_ev(EV_TX, 16'h5A, '0, -1);
      expect_ev(EV_RDREQ, 16'd1, '0, -1);
      expect_ev(EV_TX, 16'hA5, '0, -1);
      start_txn();
      send_byte(8'h12, 0); send_byte(8'h02, 0);
      wait_idle("read");
      check("read_cmd_rw", cmd_rw, 1'b0);
      check("read_tx_byte_held", tx_byte, 8'hA5);

      // Size overflow: 17 > MAX_PAYLOAD
      expect_ev(EV_ERR, 16'd2, 128'd1, -1);
      start_txn();
      send_byte(8'h81, 0); send_byte(8'h11, 0);
      wait_idle("overflow");
      check("overflow_err_code_held", err_code, 2'd2);
      check("overflow_cts_high", uart_cts, 1'b1);

      // Timeout 100 cycles after the last byte
      start_txn();
      send_byte(8'h81, 0); send_byte(8'h04, 0); send_byte(8'h01, 0);
      expect_ev(EV_ERR, 16'd3, 128'd1, t_last + TIMEOUT_CYCLES);
      wait_idle("timeout");

      // rx_error on the second payload byte, then a clean write
      expect_ev(EV_ERR, 16'd1, 128'd1, -1);
      start_txn();
      send_byte(8'h81, 0); send_byte(8'h04, 0); send_byte(8'h11, 0); send_byte(8'h22, 1);
      wait_idle("rx_error");
      check("rx_error_payload_kept", cmd_data, 128'h11);
      expect_ev(EV_WR, 16'h8201, 128'h77, -1);
      start_txn();
      send_byte(8'h82, 0); send_byte(8'h01, 0); send_byte(8'h77, 0);
      wait_idle("after_error_write");

      // Zero-size write (buffer untouched) and zero-size read (no fetch)
      expect_ev(EV_WR, 16'h8300, 128'h77, -1);
      start_txn();
      send_byte(8'h83, 0); send_byte(8'h00, 0);
      wait_idle("zero_write");
      start_txn();
      send_byte(8'h13, 0); send_byte(8'h00, 0);
      wait_idle("zero_read");

      // Reset in the middle of a write
      start_txn();
      send_byte(8'h84, 0); send_byte(8'h04, 0); send_byte(8'h01, 0);
      check("mid_write_state", state, 3'd3);
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midreset_state", state, 3'd0);
      check("midreset_cts", uart_cts, 1'b1);
      check("midreset_outputs", {cmd, data_size, cmd_data_idx, err_code}, '0);
      check("midreset_cmd_data", cmd_data, '0);
      repeat (10) @(negedge clk);
      check("midreset_no_err", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
